// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe turn arbiter.
// Cell and result encodings match the game's board and who outputs.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        X_WIN = 2'b01,
        O_WIN = 2'b10,
        DRAW  = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        TURN_X,
        TURN_O,
        ISSUE,
        SETTLE,
        OVER
    } arb_state_t;

    // True when pos names a real cell and that cell is still empty.
    function automatic logic cell_free(input logic [2*NUM_CELLS-1:0] board,
                                       input logic [3:0]             pos);
        logic free;
        free = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (pos == 4'(k)) begin
                free = (cell_t'(board[2*k +: 2]) == EMPTY);
            end
        end
        return free;
    endfunction

endpackage

// File: rtl/ttt_req_front.sv
// Per-player request front end: flags a 0->1 transition of the request level
// and presents the position sampled with it.
module ttt_req_front (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] pos,
    output logic       req_edge,
    output logic [3:0] req_pos
);

    logic req_q;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req;
        end
    end

    // The edge is decided in the same cycle it is sampled, so the arbiter can
    // answer on that clock edge; the position travels alongside it.
    assign req_edge = req & ~req_q;
    assign req_pos  = pos;

endmodule

// File: rtl/ttt_turn_arbiter.sv
// Turn arbiter in front of tic_tac_toe_game: enforces X/O alternation, validates
// moves against the live board, issues play strobes and handles timeout/restart.
module ttt_turn_arbiter
    import ttt_pkg::*;
#(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_req,
    input  logic                   o_req,
    input  logic [3:0]             x_pos,
    input  logic [3:0]             o_pos,
    output logic                   x_ack,
    output logic                   o_ack,
    output logic                   x_nack,
    output logic                   o_nack,
    input  logic                   new_game,
    input  logic [2*NUM_CELLS-1:0] board,
    input  logic [1:0]             who,
    output logic                   playX,
    output logic                   playO,
    output logic [3:0]             playerX_position,
    output logic [3:0]             playerO_position,
    output logic                   board_clr,
    output logic [1:0]             turn,
    output logic                   timeout,
    output logic [3:0]             move_count
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam arb_state_t       FIRST_STATE = (FIRST_PLAYER == 0) ? TURN_X : TURN_O;
    localparam logic [1:0]       FIRST_TURN  = (FIRST_PLAYER == 0) ? 2'b01 : 2'b10;
    localparam logic [1:0]       TURN_IS_X   = 2'b01;
    localparam logic [1:0]       TURN_IS_O   = 2'b10;

    arb_state_t       state;
    logic             mover_o;
    logic [CNT_W-1:0] tmo_cnt;

    logic       x_edge;
    logic       o_edge;
    logic [3:0] x_pos_s;
    logic [3:0] o_pos_s;
    logic       x_valid;
    logic       o_valid;
    logic       cur_o;
    logic       cur_valid;

    ttt_req_front u_front_x (
        .clk      (clk),
        .rst      (rst),
        .req      (x_req),
        .pos      (x_pos),
        .req_edge (x_edge),
        .req_pos  (x_pos_s)
    );

    ttt_req_front u_front_o (
        .clk      (clk),
        .rst      (rst),
        .req      (o_req),
        .pos      (o_pos),
        .req_edge (o_edge),
        .req_pos  (o_pos_s)
    );

    assign x_valid   = x_edge & cell_free(board, x_pos_s);
    assign o_valid   = o_edge & cell_free(board, o_pos_s);
    assign cur_o     = (state == TURN_O);
    assign cur_valid = cur_o ? o_valid : x_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FIRST_STATE;
            turn             <= FIRST_TURN;
            mover_o          <= 1'b0;
            tmo_cnt          <= '0;
            move_count       <= '0;
            x_ack            <= 1'b0;
            o_ack            <= 1'b0;
            x_nack           <= 1'b0;
            o_nack           <= 1'b0;
            playX            <= 1'b0;
            playO            <= 1'b0;
            playerX_position <= '0;
            playerO_position <= '0;
            board_clr        <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            x_ack     <= 1'b0;
            o_ack     <= 1'b0;
            x_nack    <= 1'b0;
            o_nack    <= 1'b0;
            playX     <= 1'b0;
            playO     <= 1'b0;
            board_clr <= 1'b0;
            timeout   <= 1'b0;

            if (new_game) begin
                state      <= FIRST_STATE;
                turn       <= FIRST_TURN;
                board_clr  <= 1'b1;
                move_count <= '0;
                tmo_cnt    <= '0;
                x_nack     <= x_edge;
                o_nack     <= o_edge;
            end else begin
                case (state)
                    TURN_X, TURN_O: begin
                        // The opponent is always refused; the mover only when the move is illegal.
                        x_nack <= x_edge & (cur_o | ~cur_valid);
                        o_nack <= o_edge & (~cur_o | ~cur_valid);
                        if (cur_valid) begin
                            x_ack   <= ~cur_o;
                            playX   <= ~cur_o;
                            o_ack   <= cur_o;
                            playO   <= cur_o;
                            mover_o <= cur_o;
                            state   <= ISSUE;
                            if (cur_o) begin
                                playerO_position <= o_pos_s;
                            end else begin
                                playerX_position <= x_pos_s;
                            end
                        end else if (tmo_cnt == CNT_LAST) begin
                            timeout <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= cur_o ? TURN_X : TURN_O;
                            turn    <= cur_o ? TURN_IS_X : TURN_IS_O;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end

                    ISSUE: begin
                        x_nack     <= x_edge & mover_o;
                        o_nack     <= o_edge & ~mover_o;
                        move_count <= move_count + 4'd1;
                        state      <= SETTLE;
                    end

                    SETTLE: begin
                        x_nack <= x_edge & mover_o;
                        o_nack <= o_edge & ~mover_o;
                        if (result_t'(who) != NONE || move_count == 4'(NUM_CELLS)) begin
                            state <= OVER;
                            turn  <= 2'b00;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= mover_o ? TURN_X : TURN_O;
                            turn    <= mover_o ? TURN_IS_X : TURN_IS_O;
                        end
                    end

                    OVER: begin
                        x_nack <= x_edge;
                        o_nack <= o_edge;
                    end

                    default: begin
                        state <= FIRST_STATE;
                        turn  <= FIRST_TURN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttt_turn_arbiter.sv
// Self-checking bench for ttt_turn_arbiter: a small game model drives board/who,
// a turn-level reference model predicts every registered output each cycle.
module tb_ttt_turn_arbiter;

    localparam int TMO   = 8;
    localparam int FIRST = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_req = 1'b0;
    logic        o_req = 1'b0;
    logic [3:0]  x_pos = '0;
    logic [3:0]  o_pos = '0;
    logic        new_game = 1'b0;
    logic [17:0] board = '0;
    logic [1:0]  who = '0;

    logic       x_ack, o_ack, x_nack, o_nack;
    logic       playX, playO, board_clr, timeout;
    logic [3:0] playerX_position, playerO_position, move_count;
    logic [1:0] turn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ttt_turn_arbiter #(
        .FIRST_PLAYER   (FIRST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .x_req            (x_req),
        .o_req            (o_req),
        .x_pos            (x_pos),
        .o_pos            (o_pos),
        .x_ack            (x_ack),
        .o_ack            (o_ack),
        .x_nack           (x_nack),
        .o_nack           (o_nack),
        .new_game         (new_game),
        .board            (board),
        .who              (who),
        .playX            (playX),
        .playO            (playO),
        .playerX_position (playerX_position),
        .playerO_position (playerO_position),
        .board_clr        (board_clr),
        .turn             (turn),
        .timeout          (timeout),
        .move_count       (move_count)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Game stand-in: registers each strobed move and reports a winner or draw.
    int win_lines [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

    function automatic logic [1:0] judge(input logic [17:0] b);
        logic [1:0] c0, c1, c2;
        for (int l = 0; l < 8; l++) begin
            c0 = b[2*win_lines[3*l]   +: 2];
            c1 = b[2*win_lines[3*l+1] +: 2];
            c2 = b[2*win_lines[3*l+2] +: 2];
            if (c0 != 2'b00 && c0 == c1 && c1 == c2) return c0;
        end
        for (int k = 0; k < 9; k++) begin
            if (b[2*k +: 2] == 2'b00) return 2'b00;
        end
        return 2'b11;
    endfunction

    logic [17:0] next_board;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            board <= '0;
            who   <= '0;
        end else if (board_clr) begin
            board <= '0;
            who   <= '0;
        end else if (playX || playO) begin
            next_board = board;
            if (playX) next_board[2*playerX_position +: 2] = 2'b01;
            else       next_board[2*playerO_position +: 2] = 2'b10;
            board <= next_board;
            who   <= judge(next_board);
        end
    end

    // Reference model in terms of whose turn it is and how long since a move was accepted.
    int m_player, m_since, m_idle, m_moves, m_pos;
    bit m_over, m_px, m_po, m_xe, m_oe, m_mine, m_legal;
    bit e_xa, e_oa, e_xn, e_on, e_px, e_po, e_clr, e_tmo;
    int e_xpos, e_opos, e_turn, e_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_player = FIRST; m_since = -1; m_idle = 0; m_moves = 0; m_over = 0;
            m_px = 0; m_po = 0;
            e_xa = 0; e_oa = 0; e_xn = 0; e_on = 0; e_px = 0; e_po = 0; e_clr = 0; e_tmo = 0;
            e_xpos = 0; e_opos = 0; e_cnt = 0;
            e_turn = (FIRST == 0) ? 1 : 2;
        end else begin
            m_xe = x_req && !m_px;
            m_oe = o_req && !m_po;
            m_px = x_req;
            m_po = o_req;
            e_xa = 0; e_oa = 0; e_xn = 0; e_on = 0; e_px = 0; e_po = 0; e_clr = 0; e_tmo = 0;
            if (new_game) begin
                e_clr = 1; e_xn = m_xe; e_on = m_oe;
                m_over = 0; m_player = FIRST; m_since = -1; m_idle = 0; m_moves = 0;
            end else if (m_over) begin
                e_xn = m_xe; e_on = m_oe;
            end else if (m_since >= 0) begin
                if (m_player == 0) e_on = m_oe; else e_xn = m_xe;
                if (m_since == 0) begin
                    m_moves++;
                    m_since = 1;
                end else begin
                    if (who != 2'b00 || m_moves == 9) m_over = 1;
                    else begin m_player = 1 - m_player; m_idle = 0; end
                    m_since = -1;
                end
            end else begin
                m_mine  = (m_player == 1) ? m_oe : m_xe;
                m_pos   = (m_player == 1) ? int'(o_pos) : int'(x_pos);
                m_legal = m_mine && m_pos < 9 && board[2*m_pos +: 2] == 2'b00;
                if (m_player == 0) begin e_on = m_oe; e_xn = m_xe && !m_legal; end
                else               begin e_xn = m_xe; e_on = m_oe && !m_legal; end
                if (m_legal) begin
                    if (m_player == 0) begin e_xa = 1; e_px = 1; e_xpos = m_pos; end
                    else               begin e_oa = 1; e_po = 1; e_opos = m_pos; end
                    m_since = 0;
                end else if (m_idle == TMO - 1) begin
                    e_tmo = 1; m_player = 1 - m_player; m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
            e_turn = m_over ? 0 : ((m_player == 1) ? 2 : 1);
            e_cnt  = m_moves;
        end
    end

    always @(negedge clk) begin
        check("x_ack",            int'(x_ack),            int'(e_xa));
        check("o_ack",            int'(o_ack),            int'(e_oa));
        check("x_nack",           int'(x_nack),           int'(e_xn));
        check("o_nack",           int'(o_nack),           int'(e_on));
        check("playX",            int'(playX),            int'(e_px));
        check("playO",            int'(playO),            int'(e_po));
        check("playerX_position", int'(playerX_position), e_xpos);
        check("playerO_position", int'(playerO_position), e_opos);
        check("board_clr",        int'(board_clr),        int'(e_clr));
        check("timeout",          int'(timeout),          int'(e_tmo));
        check("turn",             int'(turn),             e_turn);
        check("move_count",       int'(move_count),       e_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit is_o, input int pos);
        if (is_o) begin o_pos = 4'(pos); o_req = 1'b1; end
        else      begin x_pos = 4'(pos); x_req = 1'b1; end
        step();
        x_req = 1'b0;
        o_req = 1'b0;
    endtask

    task automatic restart();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        step();
        step();
    endtask

    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        #1 rst = 1'b0;
        repeat (10) step();
        check("reset_turn",  int'(turn),       1);
        check("reset_count", int'(move_count), 0);
        check("reset_playX", int'(playX),      0);
        rst = 1'b1;
        step();
        step();

        // First move: X takes the centre.
        press(0, 4);
        check("x4_ack",   int'(x_ack),            1);
        check("x4_playX", int'(playX),            1);
        check("x4_pos",   int'(playerX_position), 4);
        step();
        check("x4_turn_hold", int'(turn), 1);
        step();
        check("x4_turn",  int'(turn),       2);
        check("x4_count", int'(move_count), 1);

        // O's turn: occupied cell, out-of-range cell, then an X edge out of turn.
        press(1, 4);
        check("o_occupied_nack", int'(o_nack), 1);
        check("o_occupied_play", int'(playO),  0);
        step();
        press(1, 12);
        check("o_range_nack", int'(o_nack), 1);
        step();
        press(0, 0);
        check("x_outofturn_nack", int'(x_nack), 1);
        step();
        press(1, 3);
        check("o3_ack", int'(o_ack), 1);
        step();
        step();

        // X wins along the top row.
        restart();
        press(0, 0); step(); step();
        press(1, 3); step(); step();
        press(0, 1); step(); step();
        press(1, 4); step(); step();
        press(0, 2); step(); step();
        check("win_turn",  int'(turn),       0);
        check("win_count", int'(move_count), 5);
        press(0, 5);
        check("over_x_nack", int'(x_nack), 1);
        check("over_x_ack",  int'(x_ack),  0);
        step();
        press(1, 6);
        check("over_o_nack", int'(o_nack), 1);
        step();

        // Restart, then let both turns time out.
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        check("ng_clr",   int'(board_clr),  1);
        check("ng_turn",  int'(turn),       1);
        check("ng_count", int'(move_count), 0);
        repeat (7) step();
        check("tmo_x_early", int'(timeout), 0);
        step();
        check("tmo_x_pulse", int'(timeout),    1);
        check("tmo_x_turn",  int'(turn),       2);
        check("tmo_x_count", int'(move_count), 0);
        repeat (8) step();
        check("tmo_o_pulse", int'(timeout), 1);
        check("tmo_o_turn",  int'(turn),    1);
        // Valid X move on the terminal cycle beats the timeout.
        repeat (7) step();
        press(0, 0);
        check("term_x_ack", int'(x_ack),   1);
        check("term_no_tmo", int'(timeout), 0);
        step();
        step();

        // Both players request in X's turn.
        restart();
        x_pos = 4'd4; o_pos = 4'd5;
        x_req = 1'b1; o_req = 1'b1;
        step();
        check("both_x_ack",  int'(x_ack),  1);
        check("both_o_nack", int'(o_nack), 1);
        check("both_o_ack",  int'(o_ack),  0);
        x_req = 1'b0; o_req = 1'b0;
        step();
        step();

        // Full board without a winner: the ninth move ends the game.
        restart();
        for (int i = 0; i < 9; i++) begin
            press(i % 2 == 1, draw_seq[i]);
            step();
            step();
        end
        check("draw_turn",  int'(turn),       0);
        check("draw_count", int'(move_count), 9);

        // Reset in the middle of a move drops the strobe at once.
        restart();
        press(0, 4);
        check("abort_pre_playX", int'(playX), 1);
        rst = 1'b0;
        #1;
        check("abort_playX", int'(playX),      0);
        check("abort_count", int'(move_count), 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_turn", int'(turn), 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
